// File: rtl/hazard_controller.sv
// hazard_controller: decides each cycle whether IF/ID holds and a bubble enters ID/EXE,
// freezes the whole pipeline while an SRAM access is outstanding, and trips a sticky
// watchdog flag when the memory never answers.
// Optional build macro: HAZARD_PERF_EN adds saturating stall/freeze cycle counters;
// without it both counter outputs are tied to zero and no counter flops exist.
module hazard_controller #(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_forward,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             id_valid,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_read,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             err_clr,
    output logic             hold_if_id,
    output logic             bubble_id_exe,
    output logic             freeze,
    output logic             mem_timeout,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      freeze_cycles
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERROR
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] wait_cnt;
    logic [15:0] wait_cnt_next;
    logic        timeout_set;
    logic        timeout_q;
    logic        freeze_int;
    logic        raw_exe;
    logic        raw_mem;
    logic        hazard;
    logic        stall_int;

    // RAW detection against the EXE and MEM producers; write-back never stalls
    always_comb begin
        raw_exe = id_valid & exe_wb_en &
                  ((id_src1 == exe_dest) | (id_two_src & (id_src2 == exe_dest)));
        raw_mem = id_valid & mem_wb_en &
                  ((id_src1 == mem_dest) | (id_two_src & (id_src2 == mem_dest)));
        hazard  = 1'b0;
        if (enable_forward) begin
            hazard = raw_exe & exe_mem_read;
        end else begin
            hazard = raw_exe | raw_mem;
        end
    end

    // Memory-wait sequencer: next state, watchdog counter and freeze request
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        timeout_set   = 1'b0;
        freeze_int    = 1'b0;
        case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = 16'd1;
                    freeze_int    = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_next    = RUN;
                    wait_cnt_next = 16'd0;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    state_next  = ERROR;
                    timeout_set = 1'b1;
                    freeze_int  = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + 16'd1;
                    freeze_int    = 1'b1;
                end
            end
            ERROR: begin
                freeze_int = 1'b1;
                if (err_clr) begin
                    state_next    = RUN;
                    wait_cnt_next = 16'd0;
                end
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = 16'd0;
            end
        endcase
    end

    // State, watchdog counter and sticky timeout flag; only reset clears the flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            wait_cnt  <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Freeze wins over a hazard stall; the hazard is re-evaluated once unfrozen
    assign stall_int     = hazard & ~freeze_int;
    assign hold_if_id    = rst & stall_int;
    assign bubble_id_exe = rst & stall_int;
    assign freeze        = rst & freeze_int;
    assign mem_timeout   = timeout_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] freeze_cnt_q;

    // Saturating performance counters for stall and freeze cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q  <= 32'd0;
            freeze_cnt_q <= 32'd0;
        end else begin
            if (stall_int && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (freeze_int && (freeze_cnt_q != 32'hFFFF_FFFF)) begin
                freeze_cnt_q <= freeze_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles  = stall_cnt_q;
    assign freeze_cycles = freeze_cnt_q;
`else
    assign stall_cycles  = 32'd0;
    assign freeze_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed scenarios plus a randomized run checked against a
// behavioural model of the hazard rules, SRAM wait and watchdog.
`timescale 1ns/1ps
module tb_hazard_controller;

    localparam int REG_W      = 5;
    localparam int TB_TIMEOUT = 8;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             enable_forward;
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_two_src;
    logic             id_valid;
    logic [REG_W-1:0] exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_read;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wb_en;
    logic             mem_req;
    logic             mem_ready;
    logic             err_clr;
    logic             hold_if_id;
    logic             bubble_id_exe;
    logic             freeze;
    logic             mem_timeout;
    logic [31:0]      stall_cycles;
    logic [31:0]      freeze_cycles;

    int checks = 0;
    int errors = 0;

    // Behavioural model: how long the current access has been outstanding,
    // whether the memory is considered stuck, and the sticky error flag
    int     m_outstanding;
    bit     m_stuck;
    bit     m_flag;
    longint m_stall;
    longint m_frz;

    hazard_controller #(
        .REG_W   (REG_W),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable_forward (enable_forward),
        .id_src1        (id_src1),
        .id_src2        (id_src2),
        .id_two_src     (id_two_src),
        .id_valid       (id_valid),
        .exe_dest       (exe_dest),
        .exe_wb_en      (exe_wb_en),
        .exe_mem_read   (exe_mem_read),
        .mem_dest       (mem_dest),
        .mem_wb_en      (mem_wb_en),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .err_clr        (err_clr),
        .hold_if_id     (hold_if_id),
        .bubble_id_exe  (bubble_id_exe),
        .freeze         (freeze),
        .mem_timeout    (mem_timeout),
        .stall_cycles   (stall_cycles),
        .freeze_cycles  (freeze_cycles)
    );

    // 10 ns core clock
    always #5 clk = ~clk;

    function automatic bit reads(input logic [REG_W-1:0] dest, input logic wen);
        return (id_valid === 1'b1) && (wen === 1'b1) &&
               ((id_src1 == dest) || ((id_two_src === 1'b1) && (id_src2 == dest)));
    endfunction

    function automatic bit m_hazard();
        if (enable_forward === 1'b1) begin
            return reads(exe_dest, exe_wb_en) && (exe_mem_read === 1'b1);
        end
        return reads(exe_dest, exe_wb_en) || reads(mem_dest, mem_wb_en);
    endfunction

    function automatic bit m_freeze();
        if (m_stuck) return 1'b1;
        if (m_outstanding > 0) return !mem_ready;
        return mem_req && !mem_ready;
    endfunction

    task automatic model_step(input bit h, input bit f);
        if (PERF) begin
            if (h && (m_stall < 64'hFFFF_FFFF)) m_stall++;
            if (f && (m_frz < 64'hFFFF_FFFF)) m_frz++;
        end
        if (m_stuck) begin
            if (err_clr) m_stuck = 1'b0;
        end else if (m_outstanding > 0) begin
            if (mem_ready) begin
                m_outstanding = 0;
            end else if (m_outstanding == TB_TIMEOUT) begin
                m_stuck       = 1'b1;
                m_flag        = 1'b1;
                m_outstanding = 0;
            end else begin
                m_outstanding++;
            end
        end else if (mem_req && !mem_ready) begin
            m_outstanding = 1;
        end
    endtask

    task automatic clear_inputs();
        enable_forward = 1'b1;
        id_src1        = '0;
        id_src2        = '0;
        id_two_src     = 1'b0;
        id_valid       = 1'b0;
        exe_dest       = '0;
        exe_wb_en      = 1'b0;
        exe_mem_read   = 1'b0;
        mem_dest       = '0;
        mem_wb_en      = 1'b0;
        mem_req        = 1'b0;
        mem_ready      = 1'b0;
        err_clr        = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        m_outstanding = 0;
        m_stuck       = 1'b0;
        m_flag        = 1'b0;
        m_stall       = 0;
        m_frz         = 0;
    endtask

    // Load to r3 in ID/EXE, decode reads r3 as its second source
    task automatic set_load_use();
        enable_forward = 1'b1;
        id_valid       = 1'b1;
        id_src1        = 5'd1;
        id_src2        = 5'd3;
        id_two_src     = 1'b1;
        exe_dest       = 5'd3;
        exe_wb_en      = 1'b1;
        exe_mem_read   = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        clear_inputs();
        set_load_use();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        obs = {hold_if_id, bubble_id_exe, freeze, mem_timeout};
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", obs);
        end
        checks++;
        if ({stall_cycles, freeze_cycles} !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, freeze_cycles);
        end
        next_cycle();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        obs = {hold_if_id, bubble_id_exe, freeze, mem_timeout};
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got %b expected 0000", obs);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        logic [3:0] obs;
        do_reset();
        set_load_use();
        @(negedge clk);
        obs = {hold_if_id, bubble_id_exe, freeze, mem_timeout};
        checks++;
        if (obs !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL load_use_stall: got %b expected 1100", obs);
        end
        next_cycle();
        // Load has moved on to EXE/MEM, a bubble now sits in ID/EXE
        exe_dest = '0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
        mem_dest = 5'd3; mem_wb_en = 1'b1;
        @(negedge clk);
        obs = {hold_if_id, bubble_id_exe, freeze, mem_timeout};
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL load_use_released: got %b expected 0000", obs);
        end
        next_cycle();
        set_load_use();
        exe_mem_read = 1'b0;
        mem_wb_en    = 1'b0;
        @(negedge clk);
        obs = {hold_if_id, bubble_id_exe, freeze, mem_timeout};
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL alu_producer_forwarded: got %b expected 0000", obs);
        end
        next_cycle();
        set_load_use();
        id_two_src = 1'b0;
        @(negedge clk);
        obs = {hold_if_id, bubble_id_exe, freeze, mem_timeout};
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL src2_unused: got %b expected 0000", obs);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (stall_cycles !== (PERF ? 32'd1 : 32'd0)) begin
            errors++;
            $display("[TB] FAIL load_use_stall_count: got %0d expected %0d", stall_cycles, PERF ? 1 : 0);
        end
        next_cycle();
    endtask

    task automatic test_no_forward();
        bit exp;
        do_reset();
        enable_forward = 1'b0;
        id_valid       = 1'b1;
        id_src1        = 5'd5;
        exe_dest       = 5'd5;
        exe_wb_en      = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp = (c < 2);
            checks++;
            if ({hold_if_id, bubble_id_exe} !== {exp, exp}) begin
                errors++;
                $display("[TB] FAIL no_fwd_stall cycle %0d: got %b%b expected %b%b",
                         c, hold_if_id, bubble_id_exe, exp, exp);
            end
            next_cycle();
            if (c == 0) begin
                // ADD r5 moves to EXE/MEM, bubble enters ID/EXE
                mem_dest  = exe_dest;
                mem_wb_en = exe_wb_en;
                exe_dest  = '0;
                exe_wb_en = 1'b0;
            end else if (c == 1) begin
                // ADD r5 reaches write-back, which never stalls
                mem_dest  = '0;
                mem_wb_en = 1'b0;
            end else begin
                id_src1 = 5'd7;
            end
        end
        @(negedge clk);
        checks++;
        if (stall_cycles !== (PERF ? 32'd2 : 32'd0)) begin
            errors++;
            $display("[TB] FAIL no_fwd_stall_count: got %0d expected %0d", stall_cycles, PERF ? 2 : 0);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req   = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (freeze !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_same_cycle: got freeze=%b expected 0", freeze);
        end
        next_cycle();
        mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (freeze !== 1'b1) begin
                errors++;
                $display("[TB] FAIL mem_wait_freeze cycle %0d: got %b expected 1", c, freeze);
            end
            next_cycle();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (freeze !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mem_ready_release: got %b expected 0", freeze);
        end
        next_cycle();
        mem_req   = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (freeze !== 1'b0) begin
            errors++;
            $display("[TB] FAIL back_in_run: got %b expected 0", freeze);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (freeze_cycles !== (PERF ? 32'd4 : 32'd0)) begin
            errors++;
            $display("[TB] FAIL mem_wait_freeze_count: got %0d expected %0d", freeze_cycles, PERF ? 4 : 0);
        end
        next_cycle();
    endtask

    task automatic test_ready_at_watchdog();
        bit exp;
        do_reset();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        for (int c = 0; c <= TB_TIMEOUT; c++) begin
            if (c == TB_TIMEOUT) mem_ready = 1'b1;
            @(negedge clk);
            exp = (c < TB_TIMEOUT);
            checks++;
            if (freeze !== exp) begin
                errors++;
                $display("[TB] FAIL watchdog_edge_freeze cycle %0d: got %b expected %b", c, freeze, exp);
            end
            next_cycle();
        end
        mem_req   = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({freeze, mem_timeout} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL watchdog_ready_wins: got %b expected 00", {freeze, mem_timeout});
        end
        next_cycle();
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        for (int c = 0; c <= TB_TIMEOUT; c++) begin
            @(negedge clk);
            checks++;
            if ({freeze, mem_timeout} !== 2'b10) begin
                errors++;
                $display("[TB] FAIL pre_timeout cycle %0d: got %b expected 10", c, {freeze, mem_timeout});
            end
            next_cycle();
        end
        mem_req   = 1'b0;
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({freeze, mem_timeout} !== 2'b11) begin
                errors++;
                $display("[TB] FAIL error_hold cycle %0d: got %b expected 11", c, {freeze, mem_timeout});
            end
            next_cycle();
        end
        err_clr = 1'b1;
        @(negedge clk);
        checks++;
        if ({freeze, mem_timeout} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL err_clr_cycle: got %b expected 11", {freeze, mem_timeout});
        end
        next_cycle();
        err_clr   = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({freeze, mem_timeout} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL after_err_clr: got %b expected 01", {freeze, mem_timeout});
        end
        checks++;
        if (freeze_cycles !== (PERF ? 32'(TB_TIMEOUT + 5) : 32'd0)) begin
            errors++;
            $display("[TB] FAIL timeout_freeze_count: got %0d expected %0d",
                     freeze_cycles, PERF ? TB_TIMEOUT + 5 : 0);
        end
        next_cycle();
    endtask

    task automatic test_freeze_priority();
        logic [3:0] obs;
        do_reset();
        set_load_use();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            obs = {hold_if_id, bubble_id_exe, freeze, mem_timeout};
            checks++;
            if (obs !== 4'b0010) begin
                errors++;
                $display("[TB] FAIL frozen_hazard cycle %0d: got %b expected 0010", c, obs);
            end
            next_cycle();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        obs = {hold_if_id, bubble_id_exe, freeze, mem_timeout};
        checks++;
        if (obs !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL stall_after_freeze: got %b expected 1100", obs);
        end
        next_cycle();
        mem_req   = 1'b0;
        mem_ready = 1'b0;
        exe_dest = '0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
        mem_dest = 5'd3; mem_wb_en = 1'b1;
        @(negedge clk);
        obs = {hold_if_id, bubble_id_exe, freeze, mem_timeout};
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL load_moved_on: got %b expected 0000", obs);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_reset_midop();
        logic [3:0] obs;
        do_reset();
        mem_req   = 1'b1;
        mem_ready = 1'b0;
        repeat (5) next_cycle();
        set_load_use();
        #2 rst = 1'b0;
        #1;
        obs = {hold_if_id, bubble_id_exe, freeze, mem_timeout};
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midop_reset_flags: got %b expected 0000", obs);
        end
        checks++;
        if ({stall_cycles, freeze_cycles} !== 64'd0) begin
            errors++;
            $display("[TB] FAIL midop_reset_counters: got %0d/%0d expected 0/0", stall_cycles, freeze_cycles);
        end
        next_cycle();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        obs = {hold_if_id, bubble_id_exe, freeze, mem_timeout};
        checks++;
        if (obs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midop_release_run: got %b expected 0000", obs);
        end
        next_cycle();
    endtask

    task automatic test_random();
        int         ready_pct;
        bit         f;
        bit         h;
        logic [3:0] obs;
        logic [3:0] exp;
        do_reset();
        ready_pct = 90;
        for (int c = 0; c < 2000; c++) begin
            if (c % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ready_pct = 90;
                    1:       ready_pct = 40;
                    default: ready_pct = 0;
                endcase
            end
            enable_forward = ($urandom_range(0, 3) != 0);
            id_valid       = ($urandom_range(0, 4) != 0);
            id_two_src     = ($urandom_range(0, 1) != 0);
            id_src1        = REG_W'($urandom_range(0, 3));
            id_src2        = REG_W'($urandom_range(0, 3));
            exe_dest       = REG_W'($urandom_range(0, 3));
            exe_wb_en      = ($urandom_range(0, 1) != 0);
            exe_mem_read   = ($urandom_range(0, 1) != 0);
            mem_dest       = REG_W'($urandom_range(0, 3));
            mem_wb_en      = ($urandom_range(0, 1) != 0);
            mem_req        = ($urandom_range(0, 2) == 0);
            mem_ready      = (int'($urandom_range(0, 99)) < ready_pct);
            err_clr        = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            f   = m_freeze();
            h   = m_hazard() && !f;
            exp = {h, h, f, m_flag};
            obs = {hold_if_id, bubble_id_exe, freeze, mem_timeout};
            checks++;
            if (obs !== exp) begin
                errors++;
                if (errors <= 20)
                    $display("[TB] FAIL random_flags cycle %0d: got %b expected %b", c, obs, exp);
            end
            checks++;
            if ((stall_cycles !== m_stall[31:0]) || (freeze_cycles !== m_frz[31:0])) begin
                errors++;
                if (errors <= 20)
                    $display("[TB] FAIL random_counters cycle %0d: got %0d/%0d expected %0d/%0d",
                             c, stall_cycles, freeze_cycles, m_stall, m_frz);
            end
            model_step(h, f);
            next_cycle();
        end
        clear_inputs();
    endtask

    // Scenario sequence
    initial begin
        rst = 1'b1;
        clear_inputs();
        #2;
        test_reset();
        test_load_use();
        test_no_forward();
        test_mem_wait();
        test_ready_at_watchdog();
        test_timeout();
        test_freeze_priority();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and stall sequencer for the 5-stage core. It sits beside the forwarding unit and decides each cycle whether the IF/ID stages hold and a bubble enters ID/EXE. Stalls come from load-use hazards, or from any RAW hazard when forwarding is off. It also freezes the whole pipeline while the SRAM controller has not answered a memory access, and flags a stuck memory with a watchdog.

## Interface
- REG_W, 5, register-index width
- TIMEOUT, 255, maximum MEM_WAIT cycles before the watchdog trips (1..65535)
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- enable_forward  in  1  forwarding path active
- id_src1, id_src2  in  REG_W each  decode-stage source registers
- id_two_src  in  1  decode instruction reads id_src2
- id_valid  in  1  decode slot holds a real instruction
- exe_dest  in  REG_W  ID/EXE destination register
- exe_wb_en  in  1  ID/EXE instruction writes back
- exe_mem_read  in  1  ID/EXE instruction is a load
- mem_dest  in  REG_W  EXE/MEM destination register
- mem_wb_en  in  1  EXE/MEM instruction writes back
- mem_req  in  1  MEM stage is issuing an SRAM access this cycle
- mem_ready  in  1  SRAM controller completes the access this cycle
- err_clr  in  1  single-cycle pulse that clears the ERROR state
- hold_if_id  out  1  hold the PC and the IF/ID register
- bubble_id_exe  out  1  load a NOP into ID/EXE
- freeze  out  1  hold every pipeline register
- mem_timeout  out  1  sticky watchdog error flag
- stall_cycles  out  32  count of hazard-stall cycles
- freeze_cycles  out  32  count of freeze cycles

## Operation
- raw_exe = id_valid & exe_wb_en & (id_src1==exe_dest | (id_two_src & id_src2==exe_dest)).
- raw_mem is the same expression, using mem_dest and mem_wb_en.
- A write-back-stage hazard is never a stall: the register file writes before it reads.
- Hazard rule:
  - enable_forward=1: hazard = raw_exe & exe_mem_read.
  - enable_forward=0: hazard = raw_exe | raw_mem.
- FSM states: RUN, MEM_WAIT, ERROR. Reset state is RUN.
- RUN:
  - If mem_req & ~mem_ready, go to MEM_WAIT and load wait_cnt=1.
  - Otherwise stay in RUN.
- MEM_WAIT:
  - If mem_ready, go to RUN.
  - Else if wait_cnt==TIMEOUT, go to ERROR and set mem_timeout.
  - Else wait_cnt+1.
- ERROR:
  - Stay in ERROR until err_clr, then go to RUN with wait_cnt=0.
  - err_clr does not clear mem_timeout; only reset clears it.
- freeze = (RUN & mem_req & ~mem_ready) | (MEM_WAIT & ~mem_ready) | ERROR.
- hold_if_id = bubble_id_exe = hazard & ~freeze. Freeze takes priority, so a pending hazard is re-evaluated after the freeze ends.
- wait_cnt is 16 bits wide.

## Timing
- hazard, hold_if_id, bubble_id_exe and freeze are combinational from the inputs and the registered state, all within the same cycle.
- A load-use stall lasts exactly one cycle: the next edge moves the load into EXE/MEM, and forwarding then covers it.
- With forwarding off, a dependency on the EXE instruction stalls 2 cycles and a dependency on the MEM instruction stalls 1 cycle.
- If mem_ready rises in the same cycle mem_req first asserts, there is no freeze and the FSM stays in RUN.
- A mem_ready arriving in the watchdog cycle (wait_cnt==TIMEOUT) wins: the FSM returns to RUN with no error.
- Reset asserted mid-operation: FSM goes to RUN, wait_cnt=0, mem_timeout=0, counters=0. All outputs are 0 while reset is low.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cycles increments on every cycle with hold_if_id=1.
  - freeze_cycles increments on every cycle with freeze=1.
  - Both counters saturate at 32'hFFFF_FFFF and clear only on reset.
- HAZARD_PERF_EN undefined: no counter flops are built, and both outputs are tied to 0.

## Test plan
- Load to r3 in ID/EXE, with ID reading r3 as src2, id_two_src=1, enable_forward=1 -> hold_if_id=bubble_id_exe=1 for 1 cycle. Same case with exe_mem_read=0 -> no stall.
- enable_forward=0, ADD r5 enters EXE and the next instruction reads r5 -> stall high for 2 consecutive cycles, then low. stall_cycles=2 with HAZARD_PERF_EN.
- mem_req=1 with mem_ready low for 4 cycles, then high -> freeze high for 4 cycles. FSM in MEM_WAIT for 3 cycles, back in RUN after the ready edge. freeze_cycles=4.
- TIMEOUT=8, mem_ready held low -> mem_timeout rises on the edge after wait_cnt reaches 8 and freeze stays high. err_clr pulse -> RUN; mem_timeout still 1.
- Load-use hazard coincident with a freeze (mem_req=1, mem_ready=0) -> bubble_id_exe=0 while frozen. After mem_ready, the 1-cycle stall still occurs.
- rst pulled low while in MEM_WAIT with wait_cnt=5 -> all outputs 0 immediately. After release, the FSM is in RUN and mem_timeout=0.
